// File: rtl/axi4_lite_master_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared definitions for the command-driven AXI4-Lite master:
//   - AXI response codes (OKAY / EXOKAY / SLVERR / DECERR)
//   - protection field width
//   - write and read channel FSM state encodings
//   - helper to derive the byte-strobe width from the data width
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

  localparam int PROT_W = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write channel: idle, AW/W beats outstanding, waiting for B.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // Read channel: idle, AR beat outstanding, waiting for R.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  // One strobe bit per data byte; DATA_W is 32 or 64.
  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axi4_lite_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// axi4_lite_master_ctrl_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   modport master : drives addresses, data, valids and B/R readies
//   modport slave  : drives AW/W/AR readies and B/R responses
// Parameters: ADDR_W (address width), DATA_W (32 or 64).
// -----------------------------------------------------------------------------
interface axi4_lite_master_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  import axi4_lite_pkg::*;

  localparam int STRB_W = strb_width(DATA_W);

  // AW channel
  logic [ADDR_W-1:0] awaddr;
  logic [PROT_W-1:0] awprot;
  logic              awvalid;
  logic              awready;
  // W channel
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  // B channel
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  // AR channel
  logic [ADDR_W-1:0] araddr;
  logic [PROT_W-1:0] arprot;
  logic              arvalid;
  logic              arready;
  // R channel
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_lite_master_ctrl_stall_timer.sv
// -----------------------------------------------------------------------------
// axi4_lite_stall_timer
// Counts consecutive cycles a channel spends busy without any handshake.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   i_enable    : channel is outside IDLE
//   i_clear     : a handshake happened this cycle (progress was made)
//   o_expire    : this is the LIMIT-th stalled cycle; the channel must abort
// Parameter: LIMIT (stall cycles tolerated, >= 1).
// -----------------------------------------------------------------------------
module axi4_lite_stall_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear || !i_enable) begin
      r_count <= '0;
    end else if (r_count != CNT_W'(LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires combinationally so the owning FSM aborts on the edge that closes
  // the LIMIT-th stalled cycle; a same-cycle handshake counts as progress.
  assign o_expire = i_enable && !i_clear && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/axi4_lite_master_ctrl.sv
// -----------------------------------------------------------------------------
// axi4_lite_master_ctrl
// Command-driven AXI4-Lite master with independent write and read channels.
// Each channel accepts one user command while idle, runs the AXI VALID/READY
// handshakes, then returns the captured response with a one-cycle done pulse.
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   i_wr_req/addr/data/strb/prot  write command (sampled while o_wr_busy=0)
//   o_wr_busy, o_wr_done          write channel occupied / B-handshake pulse
//   o_wr_resp                     captured BRESP, held until next done
//   i_rd_req/addr/prot            read command (sampled while o_rd_busy=0)
//   o_rd_busy, o_rd_done          read channel occupied / R-handshake pulse
//   o_rd_data, o_rd_resp          captured RDATA/RRESP, held until next done
//   o_timeout_err                 sticky stall-abort flag (timeout build only)
//   m_axi                         AXI4-Lite bus, master modport
//
// Build option AXIL_MST_TIMEOUT_EN: adds a stall timer per channel. After
// TIMEOUT_CYCLES cycles without a handshake the channel drops its valid/ready,
// reports SLVERR with a done pulse and returns to idle. This abandons the bus
// transaction; the interconnect must be reset afterwards.
// -----------------------------------------------------------------------------
module axi4_lite_master_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  // write command
  input  logic                      i_wr_req,
  input  logic [ADDR_W-1:0]         i_wr_addr,
  input  logic [DATA_W-1:0]         i_wr_data,
  input  logic [DATA_W/8-1:0]       i_wr_strb,
  input  logic [PROT_W-1:0]         i_wr_prot,
  output logic                      o_wr_busy,
  output logic                      o_wr_done,
  output logic [1:0]                o_wr_resp,
  // read command
  input  logic                      i_rd_req,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  input  logic [PROT_W-1:0]         i_rd_prot,
  output logic                      o_rd_busy,
  output logic                      o_rd_done,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic [1:0]                o_rd_resp,
`ifdef AXIL_MST_TIMEOUT_EN
  output logic                      o_timeout_err,
`endif
  axi4_lite_master_ctrl_if.master   m_axi
);

  localparam int STRB_W = strb_width(DATA_W);

  // ---------------------------------------------------------------------------
  // Write channel registers
  // ---------------------------------------------------------------------------
  wr_state_e         r_wr_state;
  logic [ADDR_W-1:0] r_awaddr;
  logic [PROT_W-1:0] r_awprot;
  logic              r_awvalid;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_wr_busy;
  logic              r_wr_done;
  logic [1:0]        r_wr_resp;

  // ---------------------------------------------------------------------------
  // Read channel registers
  // ---------------------------------------------------------------------------
  rd_state_e         r_rd_state;
  logic [ADDR_W-1:0] r_araddr;
  logic [PROT_W-1:0] r_arprot;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_rd_busy;
  logic              r_rd_done;
  logic [DATA_W-1:0] r_rd_data;
  logic [1:0]        r_rd_resp;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_aw_ok, w_w_ok;
  logic w_wr_expire, w_rd_expire;

  assign w_aw_hs = r_awvalid && m_axi.awready;
  assign w_w_hs  = r_wvalid  && m_axi.wready;
  assign w_b_hs  = r_bready  && m_axi.bvalid;
  assign w_ar_hs = r_arvalid && m_axi.arready;
  assign w_r_hs  = r_rready  && m_axi.rvalid;

  // In W_XFER a beat is finished if its valid already dropped (earlier
  // handshake) or it handshakes now; both finished means move on to B.
  assign w_aw_ok = !r_awvalid || m_axi.awready;
  assign w_w_ok  = !r_wvalid  || m_axi.wready;

`ifdef AXIL_MST_TIMEOUT_EN
  logic r_timeout_err;

  axi4_lite_stall_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wr_timer (
    .clk      (clk),
    .reset    (reset),
    .i_enable (r_wr_state != W_IDLE),
    .i_clear  (w_aw_hs || w_w_hs || w_b_hs),
    .o_expire (w_wr_expire)
  );

  axi4_lite_stall_timer #(.LIMIT(TIMEOUT_CYCLES)) u_rd_timer (
    .clk      (clk),
    .reset    (reset),
    .i_enable (r_rd_state != R_IDLE),
    .i_clear  (w_ar_hs || w_r_hs),
    .o_expire (w_rd_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_wr_expire || w_rd_expire) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_wr_expire = 1'b0;
  assign w_rd_expire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  // NOTE: every state/output register uses <= so all of them see the same
  // pre-edge values; a blocking = here would let later lines see new values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Payload registers are reset too: they drive bus outputs directly and
      // must read 0 during reset.
      r_wr_state <= W_IDLE;
      r_awaddr   <= '0;
      r_awprot   <= '0;
      r_awvalid  <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_wr_busy  <= 1'b0;
      r_wr_done  <= 1'b0;
      r_wr_resp  <= RESP_OKAY;
    end else begin
      r_wr_done <= 1'b0;
      case (r_wr_state)
        W_IDLE: begin
          if (i_wr_req) begin
            r_awaddr   <= i_wr_addr;
            r_awprot   <= i_wr_prot;
            r_wdata    <= i_wr_data;
            r_wstrb    <= i_wr_strb;
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_wr_busy  <= 1'b1;
            r_wr_state <= W_XFER;
          end
        end
        W_XFER: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_bready   <= 1'b1;
            r_wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_wr_resp  <= m_axi.bresp;
            r_wr_done  <= 1'b1;
            r_bready   <= 1'b0;
            r_wr_busy  <= 1'b0;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
      // Stall abort overrides the state decode; it never coincides with a
      // handshake because any handshake clears the timer.
      if (w_wr_expire) begin
        r_awvalid  <= 1'b0;
        r_wvalid   <= 1'b0;
        r_bready   <= 1'b0;
        r_wr_resp  <= RESP_SLVERR;
        r_wr_done  <= 1'b1;
        r_wr_busy  <= 1'b0;
        r_wr_state <= W_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_state <= R_IDLE;
      r_araddr   <= '0;
      r_arprot   <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rd_busy  <= 1'b0;
      r_rd_done  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_resp  <= RESP_OKAY;
    end else begin
      r_rd_done <= 1'b0;
      case (r_rd_state)
        R_IDLE: begin
          if (i_rd_req) begin
            r_araddr   <= i_rd_addr;
            r_arprot   <= i_rd_prot;
            r_arvalid  <= 1'b1;
            r_rd_busy  <= 1'b1;
            r_rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b1;
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            r_rd_data  <= m_axi.rdata;
            r_rd_resp  <= m_axi.rresp;
            r_rd_done  <= 1'b1;
            r_rready   <= 1'b0;
            r_rd_busy  <= 1'b0;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
      if (w_rd_expire) begin
        r_arvalid  <= 1'b0;
        r_rready   <= 1'b0;
        r_rd_resp  <= RESP_SLVERR;
        r_rd_done  <= 1'b1;
        r_rd_busy  <= 1'b0;
        r_rd_state <= R_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awprot  = r_awprot;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arprot  = r_arprot;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

  assign o_wr_busy = r_wr_busy;
  assign o_wr_done = r_wr_done;
  assign o_wr_resp = r_wr_resp;
  assign o_rd_busy = r_rd_busy;
  assign o_rd_done = r_rd_done;
  assign o_rd_data = r_rd_data;
  assign o_rd_resp = r_rd_resp;

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_master_ctrl
// Directed bench for axi4_lite_master_ctrl. A small AXI slave model answers
// each channel with a programmable number of wait cycles; expected values are
// hand-derived cycle numbers and payloads. Cycle 1 is the first cycle after
// the clock edge that accepts a request. Timeout scenario runs only when
// AXIL_MST_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=8).
// -----------------------------------------------------------------------------
module tb_axi4_lite_master_ctrl;
  import axi4_lite_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              i_wr_req  = 1'b0;
  logic [ADDR_W-1:0] i_wr_addr = '0;
  logic [DATA_W-1:0] i_wr_data = '0;
  logic [STRB_W-1:0] i_wr_strb = '0;
  logic [2:0]        i_wr_prot = '0;
  logic              o_wr_busy, o_wr_done;
  logic [1:0]        o_wr_resp;
  logic              i_rd_req  = 1'b0;
  logic [ADDR_W-1:0] i_rd_addr = '0;
  logic [2:0]        i_rd_prot = '0;
  logic              o_rd_busy, o_rd_done;
  logic [DATA_W-1:0] o_rd_data;
  logic [1:0]        o_rd_resp;
`ifdef AXIL_MST_TIMEOUT_EN
  logic              o_timeout_err;
`endif

  axi4_lite_master_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi4_lite_master_ctrl #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_wr_req      (i_wr_req),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .i_wr_strb     (i_wr_strb),
    .i_wr_prot     (i_wr_prot),
    .o_wr_busy     (o_wr_busy),
    .o_wr_done     (o_wr_done),
    .o_wr_resp     (o_wr_resp),
    .i_rd_req      (i_rd_req),
    .i_rd_addr     (i_rd_addr),
    .i_rd_prot     (i_rd_prot),
    .o_rd_busy     (o_rd_busy),
    .o_rd_done     (o_rd_done),
    .o_rd_data     (o_rd_data),
    .o_rd_resp     (o_rd_resp),
`ifdef AXIL_MST_TIMEOUT_EN
    .o_timeout_err (o_timeout_err),
`endif
    .m_axi         (axi)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slave model: ready/valid rises once the master's valid/ready has been high
  // for more than *_lat cycles (0 = respond in the first cycle).
  // ---------------------------------------------------------------------------
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]        b_resp_v = RESP_OKAY;
  logic [1:0]        r_resp_v = RESP_OKAY;
  logic [DATA_W-1:0] r_data_v = '0;

  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rresp   = 2'b00;
    axi.rdata   = '0;
    forever begin
      @(negedge clk);
      aw_cnt      = axi.awvalid ? aw_cnt + 1 : 0;
      axi.awready = axi.awvalid && (aw_cnt > aw_lat);
      w_cnt       = axi.wvalid ? w_cnt + 1 : 0;
      axi.wready  = axi.wvalid && (w_cnt > w_lat);
      b_cnt       = axi.bready ? b_cnt + 1 : 0;
      axi.bvalid  = axi.bready && (b_cnt > b_lat);
      axi.bresp   = b_resp_v;
      ar_cnt      = axi.arvalid ? ar_cnt + 1 : 0;
      axi.arready = axi.arvalid && (ar_cnt > ar_lat);
      r_cnt       = axi.rready ? r_cnt + 1 : 0;
      axi.rvalid  = axi.rready && (r_cnt > r_lat);
      axi.rdata   = r_data_v;
      axi.rresp   = r_resp_v;
    end
  end

  int aw_hs_cnt = 0;
  always @(posedge clk) if (axi.awvalid && axi.awready) aw_hs_cnt <= aw_hs_cnt + 1;

  // ---------------------------------------------------------------------------
  // Stimulus helpers; each issue task returns in cycle 1.
  // ---------------------------------------------------------------------------
  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p);
    @(negedge clk);
    i_wr_req = 1'b1; i_wr_addr = a; i_wr_data = d; i_wr_strb = s; i_wr_prot = p;
    @(negedge clk);
    i_wr_req = 1'b0;
  endtask

  task automatic issue_rd(input logic [31:0] a, input logic [2:0] p);
    @(negedge clk);
    i_rd_req = 1'b1; i_rd_addr = a; i_rd_prot = p;
    @(negedge clk);
    i_rd_req = 1'b0;
  endtask

  task automatic wait_wr_done(input string tag, input int start, input int exp_cyc);
    int cyc = start;
    while (!o_wr_done && cyc < start + 60) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s wr_done cycle", tag), 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic wait_rd_done(input string tag, input int start, input int exp_cyc);
    int cyc = start;
    while (!o_rd_done && cyc < start + 60) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s rd_done cycle", tag), 64'(cyc), 64'(exp_cyc));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset valids/readies",
          {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    check("reset status", {o_wr_busy, o_wr_done, o_rd_busy, o_rd_done}, 0);
    check("reset rd_data", o_rd_data, 0);
    check("reset awaddr", axi.awaddr, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: all readies immediate, 3-cycle write
    issue_wr(32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
    check("t1 c1 aw/w valid", {axi.awvalid, axi.wvalid}, 2'b11);
    check("t1 c1 awaddr", axi.awaddr, 32'h10);
    check("t1 c1 wdata", axi.wdata, 32'hDEADBEEF);
    check("t1 c1 wstrb", axi.wstrb, 4'hF);
    check("t1 c1 busy/bready", {o_wr_busy, axi.bready}, 2'b10);
    @(negedge clk);
    check("t1 c2 aw/w valid", {axi.awvalid, axi.wvalid}, 2'b00);
    check("t1 c2 bready", axi.bready, 1'b1);
    @(negedge clk);
    check("t1 c3 wr_done", o_wr_done, 1'b1);
    check("t1 c3 wr_resp", o_wr_resp, RESP_OKAY);
    check("t1 c3 busy/bready", {o_wr_busy, axi.bready}, 2'b00);
    @(negedge clk);
    check("t1 c4 wr_done pulse end", o_wr_done, 1'b0);

    // 2: awready after 4 wait cycles, wready immediate
    aw_lat = 4;
    issue_wr(32'h44, 32'hA5A55A5A, 4'h3, 3'b010);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("t2 c%0d awvalid", c), axi.awvalid, 64'(c <= 5));
      check($sformatf("t2 c%0d wvalid", c), axi.wvalid, 64'(c == 1));
      check($sformatf("t2 c%0d bready", c), axi.bready, 64'(c == 6));
      if (c <= 5) begin
        check($sformatf("t2 c%0d awaddr", c), axi.awaddr, 32'h44);
        check($sformatf("t2 c%0d awprot", c), axi.awprot, 3'b010);
      end
      if (c < 6) @(negedge clk);
    end
    wait_wr_done("t2", 6, 7);
    aw_lat = 0;
    @(negedge clk);

    // 3: read with rvalid late, SLVERR passed through, data held after done
    r_lat = 5; r_data_v = 32'h12345678; r_resp_v = RESP_SLVERR;
    issue_rd(32'h20, 3'b001);
    check("t3 c1 arvalid", axi.arvalid, 1'b1);
    check("t3 c1 araddr", axi.araddr, 32'h20);
    check("t3 c1 arprot", axi.arprot, 3'b001);
    check("t3 c1 busy/rready", {o_rd_busy, axi.rready}, 2'b10);
    @(negedge clk);
    check("t3 c2 arvalid/rready", {axi.arvalid, axi.rready}, 2'b01);
    wait_rd_done("t3", 2, 8);
    check("t3 rd_data", o_rd_data, 32'h12345678);
    check("t3 rd_resp", o_rd_resp, RESP_SLVERR);
    check("t3 rd_busy after done", o_rd_busy, 1'b0);
    r_data_v = 32'hFFFF0000; r_resp_v = RESP_OKAY;
    repeat (3) @(negedge clk);
    check("t3 rd_data held", o_rd_data, 32'h12345678);
    check("t3 rd_resp held", o_rd_resp, RESP_SLVERR);
    check("t3 rd_done low", o_rd_done, 1'b0);
    r_lat = 0;

    // 4: concurrent write+read, second write while busy is dropped
    begin
      int hs0;
      hs0 = aw_hs_cnt;
      b_resp_v = RESP_DECERR; r_data_v = 32'hCAFEF00D; r_resp_v = RESP_EXOKAY;
      @(negedge clk);
      i_wr_req = 1'b1; i_wr_addr = 32'h30; i_wr_data = 32'h01020304;
      i_wr_strb = 4'b1010; i_wr_prot = 3'b000;
      i_rd_req = 1'b1; i_rd_addr = 32'h40; i_rd_prot = 3'b000;
      @(negedge clk);
      i_rd_req = 1'b0; i_wr_addr = 32'h99; i_wr_data = 32'h99999999;
      check("t4 c1 both busy", {o_wr_busy, o_rd_busy}, 2'b11);
      check("t4 c1 awaddr", axi.awaddr, 32'h30);
      check("t4 c1 araddr", axi.araddr, 32'h40);
      @(negedge clk);
      i_wr_req = 1'b0;
      @(negedge clk);
      check("t4 c3 dones", {o_wr_done, o_rd_done}, 2'b11);
      check("t4 wr_resp", o_wr_resp, RESP_DECERR);
      check("t4 rd_data", o_rd_data, 32'hCAFEF00D);
      check("t4 rd_resp", o_rd_resp, RESP_EXOKAY);
      repeat (4) @(negedge clk);
      check("t4 aw beats", 64'(aw_hs_cnt - hs0), 1);
      check("t4 wr_busy idle", o_wr_busy, 1'b0);
    end

    // 5: reset during W_XFER, then a fresh write
    aw_lat = 100; w_lat = 100; b_resp_v = RESP_OKAY;
    issue_wr(32'h50, 32'h55555555, 4'hF, 3'b000);
    @(negedge clk);
    check("t5 c2 stalled valids", {axi.awvalid, axi.wvalid}, 2'b11);
    reset = 1'b0;
    #1;
    check("t5 reset valids", {axi.awvalid, axi.wvalid}, 2'b00);
    check("t5 reset wr_busy", o_wr_busy, 1'b0);
    @(negedge clk);
    reset = 1'b1; aw_lat = 0; w_lat = 0;
    @(negedge clk);
    issue_wr(32'h60, 32'h600DF00D, 4'hF, 3'b000);
    check("t5 new awaddr", axi.awaddr, 32'h60);
    wait_wr_done("t5", 1, 3);
    check("t5 wr_resp", o_wr_resp, RESP_OKAY);

`ifdef AXIL_MST_TIMEOUT_EN
    // 6: arready stuck low, stall limit 8
    @(negedge clk);
    check("t6 timeout_err before", o_timeout_err, 1'b0);
    ar_lat = 1000;
    issue_rd(32'h70, 3'b000);
    wait_rd_done("t6", 1, 9);
    check("t6 rd_resp", o_rd_resp, RESP_SLVERR);
    check("t6 arvalid dropped", axi.arvalid, 1'b0);
    check("t6 rd_busy", o_rd_busy, 1'b0);
    check("t6 timeout_err", o_timeout_err, 1'b1);
    ar_lat = 0; r_data_v = 32'h0BADC0DE; r_resp_v = RESP_OKAY;
    repeat (3) @(negedge clk);
    check("t6 timeout_err sticky", o_timeout_err, 1'b1);
    issue_rd(32'h74, 3'b000);
    wait_rd_done("t6 recover", 1, 3);
    check("t6 recover rd_data", o_rd_data, 32'h0BADC0DE);
    check("t6 timeout_err still set", o_timeout_err, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/axi4_lite_master_ctrl.md
Name: axi4_lite_master_ctrl

Overview:
Command-driven AXI4-Lite master: parametrised generalisation of the team's register-forwarding master, with full VALID/READY handshake FSMs.
- Write and read channels are independent; each accepts one user command at a time.
- Each channel drives the AXI transfer and returns a registered response with a one-cycle done pulse.
- Sits between local control logic (CPU shim, sequencers) and the AXI4-Lite interconnect.

Parameters:
ADDR_W, 32, address width on user and AXI sides
DATA_W, 32, data width; legal values 32 or 64; STRB_W = DATA_W/8 is a derived localparam
TIMEOUT_CYCLES, 1024, stall limit in cycles; used only when AXIL_MST_TIMEOUT_EN is defined

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
wr_req  in  1  write command strobe, sampled when wr_busy=0
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_strb  in  STRB_W  byte strobes
wr_prot  in  3  AWPROT value
wr_busy  out  1  write channel occupied
wr_done  out  1  one-cycle pulse on B handshake
wr_resp  out  2  captured BRESP, valid with wr_done, held until next done
rd_req  in  1  read command strobe, sampled when rd_busy=0
rd_addr  in  ADDR_W  read address
rd_prot  in  3  ARPROT value
rd_busy  out  1  read channel occupied
rd_done  out  1  one-cycle pulse on R handshake
rd_data  out  DATA_W  captured RDATA, held until next rd_done
rd_resp  out  2  captured RRESP, held until next rd_done
awaddr/awprot/awvalid  out  ADDR_W/3/1  AW channel; awready  in  1
wdata/wstrb/wvalid  out  DATA_W/STRB_W/1  W channel; wready  in  1
bresp  in  2; bvalid  in  1; bready  out  1  B channel
araddr/arprot/arvalid  out  ADDR_W/3/1  AR channel; arready  in  1
rdata  in  DATA_W; rresp  in  2; rvalid  in  1; rready  out  1  R channel

Behaviour:
- Reset (async, reset=0): every output 0, both FSMs to IDLE; an in-flight transfer is abandoned and valids drop immediately.
- Write FSM states: W_IDLE, W_XFER, W_RESP.
  - W_IDLE with wr_req=1: capture addr/data/strb/prot; next cycle awvalid=wvalid=1, wr_busy=1, state W_XFER.
  - W_XFER: awvalid and wvalid each clear independently in the cycle after their own handshake (valid&ready at the edge). Payload is stable while valid is high; valid never drops before ready.
  - W_XFER exits to W_RESP once both handshakes have occurred, including both in the same cycle.
  - bready=1 only in W_RESP. A bvalid arriving earlier is ignored.
  - W_RESP with bvalid=1: capture bresp into wr_resp, pulse wr_done next cycle, return to W_IDLE. wr_busy falls with wr_done.
  - Minimum latency, with AXI ready tied high: wr_req to wr_done = 3 cycles.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE with rd_req=1: capture inputs; next cycle arvalid=1, rd_busy=1.
  - R_ADDR: arvalid held until the arready handshake, then R_DATA.
  - rready=1 only in R_DATA. On rvalid, capture rdata/rresp, pulse rd_done, return to R_IDLE.
  - Minimum latency: 3 cycles.
- wr_req/rd_req asserted while busy: ignored, no queuing. A new request is accepted in the cycle after done, when busy=0.
- Read and write run concurrently; there is no ordering between channels.
- Response codes are passed through unmodified (SLVERR/DECERR do not alter FSM flow).

Optional Feature:
AXIL_MST_TIMEOUT_EN
- Defined: each channel has a stall counter, cleared on every handshake and in IDLE.
  - When the counter reaches TIMEOUT_CYCLES, the channel forces its done pulse with resp=2'b10 (SLVERR) and returns to IDLE.
  - The channel also drops its valid/ready. This is a deliberate protocol abort; the interconnect must then be reset.
  - Extra port timeout_err (out, 1) is sticky and cleared only by reset.
- Undefined: no counters, no timeout_err port; the channel waits indefinitely.

Decomposition:
- Package axi4_lite_pkg holds:
  - response localparams RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - PROT_W=3;
  - write and read FSM state encodings.
- Sub-module axi4_lite_stall_timer (counter, clear, expire), instantiated once per channel under the macro.

Test Plan:
1. All AXI readies=1, wr_req with addr 0x10, data 0xDEADBEEF, strb 0xF -> AW/W valid for 1 cycle each; wr_done at cycle 3; wr_resp=00.
2. awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles with stable payload; bready not asserted before the AW handshake.
3. rd_req with addr 0x20, rvalid after 6 cycles with rdata 0x12345678 and rresp 10 -> rd_done pulse; rd_data=0x12345678, rd_resp=10, held after done.
4. Concurrent wr_req and rd_req in the same cycle, plus a second wr_req while busy -> both complete; the second wr_req is dropped, with no extra AW beat.
5. Assert reset=0 mid-W_XFER -> awvalid, wvalid, wr_busy at 0 immediately; a fresh wr_req after release completes normally.
6. With AXIL_MST_TIMEOUT_EN and TIMEOUT_CYCLES=8, arready stuck at 0 -> rd_done at cycle 9 with rd_resp=10; timeout_err=1 and stays set.
